// File: rtl/iter_exec_pkg.sv
// rtl/iter_exec_pkg.sv - shared types for the iterative execution unit
package iter_exec_pkg;

  typedef enum logic [1:0] {
    kRLZ = 2'd0,
    kDIV = 2'd1,
    kSEQ = 2'd2,
    kILL = 2'd3
  } iter_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } iter_state_t;

  localparam int DW_DEFAULT = 8;
  localparam int PW_DEFAULT = 4;

  // Opcodes the unit actually executes; anything else reports ERR.
  function automatic logic is_legal(input iter_op_t op);
    return (op != kILL);
  endfunction

endpackage

// File: rtl/iter_exec_if.sv
// rtl/iter_exec_if.sv - launch/result bundle between control and the iterative unit
interface iter_exec_if
  import iter_exec_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int PW = PW_DEFAULT
);

  logic          start;
  iter_op_t      OP;
  logic [DW-1:0] INPUTA;
  logic [DW-1:0] INPUTB;
  logic [PW-1:0] INPUTD;
  logic          busy;
  logic          done;
  logic [DW-1:0] RESULT;
  logic [DW-1:0] AUX;
  logic          ZERO;
  logic          ERR;

  modport master (
    output start, OP, INPUTA, INPUTB, INPUTD,
    input  busy, done, RESULT, AUX, ZERO, ERR
  );

  modport slave (
    input  start, OP, INPUTA, INPUTB, INPUTD,
    output busy, done, RESULT, AUX, ZERO, ERR
  );

endinterface

// File: rtl/iter_exec_pat_match.sv
// rtl/iter_exec_pat_match.sv - compares one PW-bit window of the source against the pattern
module iter_exec_pat_match #(
  parameter int DW = 8,
  parameter int PW = 4
) (
  input  logic [DW-1:0] src,
  input  logic [2:0]    win,
  input  logic [PW-1:0] pat,
  output logic          match
);

  logic [DW-1:0] shifted;

  // Window 0 is the most significant PW bits; each step slides one bit toward the LSB.
  always_comb begin
    shifted = src >> (3'(DW - PW) - win);
    match   = (shifted[PW-1:0] == pat);
  end

endmodule

// File: rtl/iter_exec.sv
// rtl/iter_exec.sv - multi-cycle RLZ / DIV / SEQ execution unit
module iter_exec
  import iter_exec_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int PW = PW_DEFAULT
) (
  input logic      CLK,
  input logic      reset,
  iter_exec_if.slave bus
);

  localparam logic [DW-1:0] CNT_MAX  = DW'(DW);
  localparam logic [DW-1:0] ONE      = DW'(1);
  localparam logic [2:0]    WIN_LAST = 3'(DW - PW);

  iter_state_t   state, state_nxt;
  iter_op_t      op_q, op_nxt;
  logic [DW-1:0] acc, acc_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] div_b, div_b_nxt;
  logic [PW-1:0] pat, pat_nxt;
  logic [2:0]    win, win_nxt;
  logic [DW-1:0] result, result_nxt;
  logic [DW-1:0] aux, aux_nxt;
  logic          zero, zero_nxt;
  logic          err, err_nxt;
  logic          match;
  logic [DW-1:0] seq_cnt;

  // acc doubles as the SEQ source register, so the window compare reads it directly.
  iter_exec_pat_match #(.DW(DW), .PW(PW)) u_pat_match (
    .src   (acc),
    .win   (win),
    .pat   (pat),
    .match (match)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and one datapath step per RUN cycle; results are written only on exit.
  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    div_b_nxt  = div_b;
    pat_nxt    = pat;
    win_nxt    = win;
    result_nxt = result;
    aux_nxt    = aux;
    zero_nxt   = zero;
    err_nxt    = err;
    seq_cnt    = match ? (cnt + ONE) : cnt;

    case (state)
      IDLE: begin
        if (bus.start) begin
          op_nxt    = bus.OP;
          acc_nxt   = bus.INPUTA;
          div_b_nxt = bus.INPUTB;
          pat_nxt   = bus.INPUTD;
          cnt_nxt   = '0;
          win_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        case (op_q)
          kRLZ: begin
            if (acc[DW-1] || (cnt == CNT_MAX)) begin
              result_nxt = acc;
              aux_nxt    = cnt;
              zero_nxt   = (acc == '0);
              state_nxt  = DONE;
            end else begin
              acc_nxt = {acc[DW-2:0], 1'b0};
              cnt_nxt = cnt + ONE;
            end
          end
          kDIV: begin
            if (div_b == '0) begin
              result_nxt = '1;
              aux_nxt    = acc;
              zero_nxt   = 1'b0;
              err_nxt    = 1'b1;
              state_nxt  = DONE;
            end else if (acc >= div_b) begin
              acc_nxt = acc - div_b;
              cnt_nxt = cnt + ONE;
            end else begin
              result_nxt = cnt;
              aux_nxt    = acc;
              zero_nxt   = (cnt == '0);
              state_nxt  = DONE;
            end
          end
          kSEQ: begin
            if (win == WIN_LAST) begin
              result_nxt = '0;
              aux_nxt    = seq_cnt;
              zero_nxt   = 1'b1;
              state_nxt  = DONE;
            end else begin
              cnt_nxt = seq_cnt;
              win_nxt = win + 3'd1;
            end
          end
          default: begin
            result_nxt = '0;
            aux_nxt    = '0;
            zero_nxt   = 1'b1;
            err_nxt    = !is_legal(op_q);
            state_nxt  = DONE;
          end
        endcase
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, working and result registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      op_q   <= kRLZ;
      acc    <= '0;
      cnt    <= '0;
      div_b  <= '0;
      pat    <= '0;
      win    <= '0;
      result <= '0;
      aux    <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else begin
      op_q   <= op_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      div_b  <= div_b_nxt;
      pat    <= pat_nxt;
      win    <= win_nxt;
      result <= result_nxt;
      aux    <= aux_nxt;
      zero   <= zero_nxt;
      err    <= err_nxt;
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.RESULT = result;
  assign bus.AUX    = aux;
  assign bus.ZERO   = zero;
  assign bus.ERR    = err;

endmodule

// File: tb/tb_iter_exec.sv
// tb/tb_iter_exec.sv - randomized self-checking bench for iter_exec
module tb_iter_exec;
  import iter_exec_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  iter_exec_if #(.DW(8), .PW(4)) bus ();

  iter_exec #(.DW(8), .PW(4)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: results derived directly from the arithmetic meaning of each op.
  function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] d, output logic [7:0] r, output logic [7:0] x,
                                output logic z, output logic e, output int cyc);
    int n;
    int hits;
    logic [7:0] win;
    r = 8'h00; x = 8'h00; e = 1'b0; cyc = 1;
    case (op)
      2'd0: begin
        if (a == 8'h00) begin
          r = 8'h00; x = 8'd8; cyc = 9;
        end else begin
          n = 0;
          while (((a << n) & 8'h80) == 8'h00) n++;
          r = a << n; x = 8'(n); cyc = n + 1;
        end
      end
      2'd1: begin
        if (b == 8'h00) begin
          r = 8'hFF; x = a; e = 1'b1; cyc = 1;
        end else begin
          r = a / b; x = a % b; cyc = int'(a / b) + 1;
        end
      end
      2'd2: begin
        hits = 0;
        for (int w = 0; w < 5; w++) begin
          win = (a >> (4 - w)) & 8'h0F;
          if (win[3:0] == d) hits++;
        end
        r = 8'h00; x = 8'(hits); cyc = 5;
      end
      default: begin
        r = 8'h00; x = 8'h00; e = 1'b1; cyc = 1;
      end
    endcase
    z = (r == 8'h00);
  endfunction

  // Launch one op from IDLE and wait for done; returns what was observed in the DONE cycle.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] d, input bit scramble, output int cyc,
                       output logic dn, output logic [7:0] r, output logic [7:0] x,
                       output logic z, output logic e);
    @(negedge clk);
    bus.start = 1'b1; bus.OP = iter_op_t'(op); bus.INPUTA = a; bus.INPUTB = b; bus.INPUTD = d;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 400) begin
      cyc++;
      if (scramble) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.OP     = iter_op_t'($urandom_range(0, 3));
        bus.INPUTA = 8'($urandom); bus.INPUTB = 8'($urandom); bus.INPUTD = 4'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    dn = bus.done; r = bus.RESULT; x = bus.AUX; z = bus.ZERO; e = bus.ERR;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    if (bus.done !== 1'b0)     begin errors++; $display("FAIL reset_done got %0b exp 0", bus.done); end
    if (bus.RESULT !== 8'h00)  begin errors++; $display("FAIL reset_result got %0h exp 0", bus.RESULT); end
    if (bus.AUX !== 8'h00)     begin errors++; $display("FAIL reset_aux got %0h exp 0", bus.AUX); end
    if (bus.ZERO !== 1'b0)     begin errors++; $display("FAIL reset_zero got %0b exp 0", bus.ZERO); end
    if (bus.ERR !== 1'b0)      begin errors++; $display("FAIL reset_err got %0b exp 0", bus.ERR); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0] op_t [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [7:0] a_t [6]  = '{8'h13, 8'h00, 8'd100, 8'd9, 8'hAA, 8'hFF};
    logic [7:0] b_t [6]  = '{8'h00, 8'h00, 8'd7, 8'd0, 8'h00, 8'h00};
    logic [3:0] d_t [6]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'hF};
    int         c_t [6]  = '{4, 9, 15, 1, 5, 5};
    logic [7:0] r_t [6]  = '{8'h98, 8'h00, 8'd14, 8'hFF, 8'h00, 8'h00};
    logic [7:0] x_t [6]  = '{8'd3, 8'd8, 8'd2, 8'd9, 8'd3, 8'd5};
    logic       z_t [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       e_t [6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int cyc; logic dn, z, e; logic [7:0] r, x;
    for (int i = 0; i < 6; i++) begin
      do_op(op_t[i], a_t[i], b_t[i], d_t[i], 1'b0, cyc, dn, r, x, z, e);
      checks += 6;
      if (cyc !== c_t[i]) begin errors++; $display("FAIL dir%0d_run_cycles got %0d exp %0d", i, cyc, c_t[i]); end
      if (dn !== 1'b1)    begin errors++; $display("FAIL dir%0d_done got %0b exp 1", i, dn); end
      if (r !== r_t[i])   begin errors++; $display("FAIL dir%0d_result got %0h exp %0h", i, r, r_t[i]); end
      if (x !== x_t[i])   begin errors++; $display("FAIL dir%0d_aux got %0h exp %0h", i, x, x_t[i]); end
      if (z !== z_t[i])   begin errors++; $display("FAIL dir%0d_zero got %0b exp %0b", i, z, z_t[i]); end
      if (e !== e_t[i])   begin errors++; $display("FAIL dir%0d_err got %0b exp %0b", i, e, e_t[i]); end
      @(negedge clk);
      checks += 2;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got %0b exp 0", i, bus.done); end
      if (bus.RESULT !== r_t[i] || bus.AUX !== x_t[i]) begin
        errors++; $display("FAIL dir%0d_hold got %0h/%0h exp %0h/%0h", i, bus.RESULT, bus.AUX, r_t[i], x_t[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op; logic [7:0] a, b; logic [3:0] d;
    logic [7:0] er, ex; logic ez, ee; int ec;
    int cyc; logic dn, z, e; logic [7:0] r, x;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      d  = ($urandom_range(0, 1) == 1) ? a[5:2] : 4'($urandom);
      if (op == 2'd0 && $urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 7);
      model(op, a, b, d, er, ex, ez, ee, ec);
      do_op(op, a, b, d, 1'b1, cyc, dn, r, x, z, e);
      checks += 6;
      if (cyc !== ec)   begin errors++; $display("FAIL rnd%0d_run_cycles op %0d got %0d exp %0d", i, op, cyc, ec); end
      if (dn !== 1'b1)  begin errors++; $display("FAIL rnd%0d_done got %0b exp 1", i, dn); end
      if (r !== er)     begin errors++; $display("FAIL rnd%0d_result op %0d a %0h b %0h got %0h exp %0h", i, op, a, b, r, er); end
      if (x !== ex)     begin errors++; $display("FAIL rnd%0d_aux op %0d a %0h b %0h d %0h got %0h exp %0h", i, op, a, b, d, x, ex); end
      if (z !== ez)     begin errors++; $display("FAIL rnd%0d_zero got %0b exp %0b", i, z, ez); end
      if (e !== ee)     begin errors++; $display("FAIL rnd%0d_err got %0b exp %0b", i, e, ee); end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_after_done got busy %0b done %0b exp 0 0", i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int n; bit saw;
    @(negedge clk);
    bus.start = 1'b1; bus.OP = kDIV; bus.INPUTA = 8'd200; bus.INPUTB = 8'd1; bus.INPUTD = 4'h0;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %0b exp 1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 6;
    if (bus.busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got %0b exp 0", bus.busy); end
    if (bus.done !== 1'b0)    begin errors++; $display("FAIL midrst_done got %0b exp 0", bus.done); end
    if (bus.RESULT !== 8'h00) begin errors++; $display("FAIL midrst_result got %0h exp 0", bus.RESULT); end
    if (bus.AUX !== 8'h00)    begin errors++; $display("FAIL midrst_aux got %0h exp 0", bus.AUX); end
    if (bus.ZERO !== 1'b0)    begin errors++; $display("FAIL midrst_zero got %0b exp 0", bus.ZERO); end
    if (bus.ERR !== 1'b0)     begin errors++; $display("FAIL midrst_err got %0b exp 0", bus.ERR); end
    saw = 1'b0;
    repeat (20) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) saw = 1'b1; end
    checks++;
    if (saw) begin errors++; $display("FAIL midrst_no_done got activity 1 exp 0"); end
  endtask

  task automatic test_start_ignored();
    int cyc; logic dn, z, e; logic [7:0] r, x;
    do_op(2'd1, 8'd100, 8'd7, 4'h0, 1'b1, cyc, dn, r, x, z, e);
    checks += 4;
    if (cyc !== 15)    begin errors++; $display("FAIL busy_start_cycles got %0d exp 15", cyc); end
    if (dn !== 1'b1)   begin errors++; $display("FAIL busy_start_done got %0b exp 1", dn); end
    if (r !== 8'd14)   begin errors++; $display("FAIL busy_start_result got %0h exp e", r); end
    if (x !== 8'd2)    begin errors++; $display("FAIL busy_start_aux got %0h exp 2", x); end
    bus.start = 1'b1; bus.OP = kRLZ; bus.INPUTA = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.busy !== 1'b0)  begin errors++; $display("FAIL done_start_busy got %0b exp 0", bus.busy); end
    if (bus.RESULT !== 8'd14 || bus.AUX !== 8'd2) begin
      errors++; $display("FAIL done_start_hold got %0h/%0h exp e/2", bus.RESULT, bus.AUX);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.OP = kRLZ; bus.INPUTA = 8'h00; bus.INPUTB = 8'h00; bus.INPUTD = 4'h0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_run();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
